// File: rtl/cache_refill_ctrl.sv
// Miss-refill controller for a set-associative, write-through cache.
// It picks a victim way on a miss and fetches the line with one burst read.
// Each returned beat is written into the data/tag RAMs.
// On completion it pulses the pseudo-LRU update with the one-hot victim.
module cache_refill_ctrl #(
  parameter int SET_ASSOC  = 4,
  parameter int LINE_WORDS = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_req,
  input  logic [ADDR_WIDTH-1:0]         miss_addr,
  input  logic [SET_ASSOC-1:0]          way_valid,
  input  logic [$clog2(SET_ASSOC)-1:0]  repl_index,
  output logic                          busy,
  output logic                          mem_rd_req,
  output logic [ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic                          mem_rd_gnt,
  input  logic                          mem_rvalid,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          line_we,
  output logic [$clog2(SET_ASSOC)-1:0]  line_way,
  output logic [$clog2(LINE_WORDS)-1:0] line_word,
  output logic [DATA_WIDTH-1:0]         line_wdata,
  output logic [SET_ASSOC-1:0]          plru_access,
  output logic                          plru_update,
  output logic                          refill_done
);

  localparam int OFS_W  = $clog2(LINE_WORDS * DATA_WIDTH / 8);
  localparam int WAY_W  = $clog2(SET_ASSOC);
  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam logic [WORD_W-1:0]    LAST_WORD = WORD_W'(LINE_WORDS - 1);
  localparam logic [SET_ASSOC-1:0] ONE_HOT_0 = {{(SET_ASSOC-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RECV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [WORD_W-1:0] beat_cnt;
  logic              beat_accept;
  logic              last_beat;

  // Lowest-index invalid way wins; otherwise fall back to the pseudo-LRU choice.
  function automatic logic [WAY_W-1:0] pick_victim(input logic [SET_ASSOC-1:0] valid,
                                                    input logic [WAY_W-1:0]     plru);
    logic [WAY_W-1:0] victim;
    logic             found;
    victim = plru;
    found  = 1'b0;
    for (int i = 0; i < SET_ASSOC; i++) begin
      if (!found && !valid[i]) begin
        victim = WAY_W'(i);
        found  = 1'b1;
      end
    end
    return victim;
  endfunction

  assign beat_accept = (state == RECV) && mem_rvalid;
  assign last_beat   = beat_accept && (beat_cnt == LAST_WORD);

  // Next-state decode: a miss starts a refill; the grant opens the data phase.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (miss_req)   next_state = REQ;  else next_state = IDLE;
      REQ:     if (mem_rd_gnt) next_state = RECV; else next_state = REQ;
      RECV:    if (last_beat)  next_state = DONE; else next_state = RECV;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Capture victim way and line-aligned address once, when the miss is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_way    <= '0;
      mem_rd_addr <= '0;
    end else if (state == IDLE && miss_req) begin
      line_way    <= pick_victim(way_valid, repl_index);
      mem_rd_addr <= {miss_addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};
    end
  end

  // Beat counter: cleared on grant, advanced on each beat taken in RECV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            beat_cnt <= '0;
    else if (state == REQ && mem_rd_gnt) beat_cnt <= '0;
    else if (beat_accept)                beat_cnt <= beat_cnt + WORD_W'(1);
  end

  // RAM write port: one registered write per accepted beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_we    <= 1'b0;
      line_word  <= '0;
      line_wdata <= '0;
    end else begin
      line_we <= beat_accept;
      if (beat_accept) begin
        line_word  <= beat_cnt;
        line_wdata <= mem_rdata;
      end
    end
  end

  // Status/handshake outputs registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy        <= 1'b0;
      mem_rd_req  <= 1'b0;
      refill_done <= 1'b0;
      plru_update <= 1'b0;
      plru_access <= '0;
    end else begin
      busy        <= (next_state != IDLE);
      mem_rd_req  <= (next_state == REQ);
      refill_done <= (next_state == DONE);
      plru_update <= (next_state == DONE);
      plru_access <= (next_state == DONE) ? (ONE_HOT_0 << line_way) : '0;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Self-checking bench for cache_refill_ctrl: directed scenarios plus randomized refills
// checked against a behavioural model of victim choice, alignment and beat ordering.
module tb_cache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req;
  logic [31:0] miss_addr;
  logic [3:0]  way_valid;
  logic [1:0]  repl_index;
  logic        busy;
  logic        mem_rd_req;
  logic [31:0] mem_rd_addr;
  logic        mem_rd_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        line_we;
  logic [1:0]  line_way;
  logic [2:0]  line_word;
  logic [31:0] line_wdata;
  logic [3:0]  plru_access;
  logic        plru_update;
  logic        refill_done;

  int checks = 0;
  int errors = 0;

  cache_refill_ctrl #(.SET_ASSOC(4), .LINE_WORDS(8), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .way_valid(way_valid), .repl_index(repl_index), .busy(busy),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_gnt(mem_rd_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .line_we(line_we),
    .line_way(line_way), .line_word(line_word), .line_wdata(line_wdata),
    .plru_access(plru_access), .plru_update(plru_update), .refill_done(refill_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: lowest invalid way, else the pseudo-LRU way.
  function automatic logic [1:0] ref_victim(input logic [3:0] v, input logic [1:0] r);
    for (int i = 0; i < 4; i++) if (!v[i]) return 2'(i);
    return r;
  endfunction

  function automatic logic [127:0] all_outputs();
    return {busy, mem_rd_req, mem_rd_addr, line_we, line_way, line_word,
            line_wdata, plru_access, plru_update, refill_done};
  endfunction

  // One refill transaction. pat_len>0 gives a fixed rvalid pattern (LSB first, 1 after it);
  // noisy drives stray/ignored inputs; abort_after>=0 resets after that many beats.
  task automatic run_refill(input logic [31:0] addr, input logic [3:0] valid,
                            input logic [1:0] repl, input int gnt_wait,
                            input logic [31:0] pat, input int pat_len,
                            input bit noisy, input int abort_after);
    logic [1:0]  vic;
    logic [31:0] aligned;
    logic [31:0] data;
    logic        v;
    int          cnt;
    int          cyc;
    bit          done_exp;
    vic     = ref_victim(valid, repl);
    aligned = addr - (addr % 32);
    miss_req = 1'b1; miss_addr = addr; way_valid = valid; repl_index = repl;
    mem_rvalid = 1'b0; mem_rd_gnt = 1'b0;
    step();
    check("req_start", {busy, mem_rd_req, line_we}, 3'b110);
    check("rd_addr", mem_rd_addr, aligned);
    check("victim", line_way, vic);
    if (noisy) begin
      miss_addr = $urandom; way_valid = 4'($urandom); repl_index = 2'($urandom);
    end
    for (int w = 0; w < gnt_wait; w++) begin
      mem_rvalid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      step();
      check("req_hold", {mem_rd_req, line_we}, 2'b10);
      check("rd_addr_hold", mem_rd_addr, aligned);
    end
    mem_rvalid = 1'b0; mem_rd_gnt = 1'b1;
    step();
    mem_rd_gnt = 1'b0;
    check("req_drop", {busy, mem_rd_req}, 2'b10);
    cnt = 0; cyc = 0;
    while (cnt < 8 && cyc < 200) begin
      v    = (cyc < pat_len) ? pat[cyc] : ((pat_len > 0) ? 1'b1 : 1'($urandom_range(0, 2) != 0));
      data = $urandom;
      mem_rvalid = v; mem_rdata = data;
      if (noisy) begin
        miss_req = 1'($urandom_range(0, 1)); mem_rd_gnt = 1'($urandom_range(0, 1));
      end
      step();
      check("line_we", line_we, v);
      if (v) begin
        check("line_word", line_word, cnt);
        check("line_wdata", line_wdata, data);
        cnt++;
      end
      done_exp = v && (cnt == 8);
      check("done_pulse", {refill_done, plru_update}, {done_exp, done_exp});
      check("plru_access", plru_access, done_exp ? (4'b0001 << vic) : 4'b0000);
      check("victim_stable", {line_way, mem_rd_addr}, {vic, aligned});
      check("busy_recv", {busy, mem_rd_req}, 2'b10);
      cyc++;
      if (abort_after >= 0 && cnt == abort_after) begin
        mem_rvalid = 1'b0; miss_req = 1'b0; mem_rd_gnt = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst", all_outputs(), 128'd0);
        step();
        check("rst_hold", all_outputs(), 128'd0);
        @(negedge clk) rst = 1'b0;
        return;
      end
    end
    if (cnt < 8) begin
      checks++; errors++;
      $error("FAIL beat_timeout: observed %0d beats expected 8", cnt);
    end
    mem_rvalid = 1'b0; miss_req = 1'b0; mem_rd_gnt = 1'b0;
    step();
    check("back_idle", {busy, refill_done, plru_update, line_we}, 4'b0000);
  endtask

  initial begin
    rst = 1'b1; miss_req = 1'b0; miss_addr = '0; way_valid = '0; repl_index = '0;
    mem_rd_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #1 check("reset_outputs", all_outputs(), 128'd0);
    step(); step();
    @(negedge clk) rst = 1'b0;

    // Stray read beats and grants while idle must be ignored.
    mem_rvalid = 1'b1; mem_rd_gnt = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step(); step();
    check("idle_stray", {busy, mem_rd_req, line_we, refill_done}, 4'b0000);
    mem_rvalid = 1'b0; mem_rd_gnt = 1'b0;

    // Invalid way 0 chosen, address aligned to 32 bytes.
    run_refill(32'h1000_0044, 4'b0000, 2'd3, 0, 32'd0, 0, 1'b0, -1);
    // All valid: pseudo-LRU way.
    run_refill(32'h2000_0010, 4'b1111, 2'd2, 1, 32'd0, 0, 1'b0, -1);
    // Invalid way 2 beats pseudo-LRU way 0.
    run_refill(32'h3000_007C, 4'b1011, 2'd0, 2, 32'd0, 0, 1'b0, -1);
    // Grant delayed 5 cycles, fixed rvalid gap pattern 1,0,1,1,0,0,1,1,1,1,1.
    run_refill(32'h4000_0123, 4'b0111, 2'd1, 5, 32'b111_1100_1101, 11, 1'b0, -1);
    // Stray inputs: miss_req toggling, grants and samples changing during the refill.
    run_refill(32'h5555_5555, 4'b1101, 2'd3, 3, 32'd0, 0, 1'b1, -1);
    // Reset after three beats, then a clean refill restarting at word 0.
    run_refill(32'h6000_0040, 4'b1110, 2'd2, 1, 32'd0, 0, 1'b0, 3);
    run_refill(32'h7000_0008, 4'b1111, 2'd1, 0, 32'd0, 0, 1'b0, -1);
    // Randomized refills.
    for (int n = 0; n < 8; n++) begin
      run_refill($urandom, 4'($urandom), 2'($urandom), $urandom_range(0, 4),
                 32'd0, 0, 1'($urandom_range(0, 1)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
